// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor with start/busy/done handshake and Y86 condition codes.
// Optional flag logic (zf/sf/of) is enabled by defining SERIAL_ADDSUB_FLAGS_EN.
module serial_addsub #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int unsigned IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IW-1:0]    idx;

  logic             a_bit;
  logic             b_bit;
  logic             s_bit;
  logic             c_next;
  logic             last;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    a_bit         = a_q[idx];
    b_bit         = b_q[idx];
    s_bit         = a_bit ^ b_bit ^ carry;
    c_next        = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
    last          = (idx == IW'(WIDTH - 1));
    res_next      = result;
    res_next[idx] = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
      zf     <= 1'b0;
      sf     <= 1'b0;
      of     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= op ? ~b : b;
            carry  <= op;
            idx    <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          result <= res_next;
          carry  <= c_next;
          idx    <= idx + IW'(1);
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= c_next;
`ifdef SERIAL_ADDSUB_FLAGS_EN
            // On the MSB step the live carry register is the carry into the MSB,
            // so overflow is taken directly without a separate c_msb copy.
            zf    <= (res_next == '0);
            sf    <= s_bit;
            of    <= carry ^ c_next;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SERIAL_ADDSUB_FLAGS_EN
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_serial_addsub;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zf;
  logic         sf;
  logic         of;

  int n_checks = 0;
  int n_err    = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zf     (zf),
    .sf     (sf),
    .of     (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic opv,
                                output logic [W-1:0] r, output logic c,
                                output logic z, output logic s, output logic o);
    logic [W:0] sum;
    if (opv) sum = {1'b0, av} - {1'b0, bv} + {1'b1, {W{1'b0}}};
    else     sum = {1'b0, av} + {1'b0, bv};
    r = sum[W-1:0];
    c = sum[W];
`ifdef SERIAL_ADDSUB_FLAGS_EN
    z = (r == '0);
    s = r[W-1];
    if (opv) o = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
    else     o = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
`else
    z = 1'b0;
    s = 1'b0;
    o = 1'b0;
`endif
  endfunction

  // mode 0: plain, 1: scramble inputs and pulse start during RUN, 2: hold start high
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic opv, input int mode);
    logic [W-1:0] er;
    logic         ec, ez, es, eo;
    int           edges;
    int           bcnt;
    int           overlap;
    bit           seen;
    model(av, bv, opv, er, ec, ez, es, eo);
    @(negedge clk);
    a_i = av; b_i = bv; op_i = opv; start = 1'b1;
    @(posedge clk); #1;
    check("busy_on_accept", 64'(busy), 64'(1));
    check("result_cleared", result, 64'(0));
    if (mode != 2) start = 1'b0;
    edges = 0; bcnt = 1; overlap = 0; seen = 0;
    while (!seen && edges < 200) begin
      if (mode == 1) begin
        a_i   = {$urandom, $urandom};
        b_i   = {$urandom, $urandom};
        op_i  = 1'($urandom_range(1, 0));
        start = 1'($urandom_range(1, 0));
      end
      @(posedge clk); #1;
      edges++;
      if (busy && done) overlap++;
      if (done) seen = 1;
      else if (busy) bcnt++;
    end
    if (mode == 1) start = 1'b0;
    check("done_edge", 64'(edges), 64'(W));
    check("busy_cycles", 64'(bcnt), 64'(W));
    check("busy_done_overlap", 64'(overlap), 64'(0));
    check("result", result, er);
    check("cout", 64'(cout), 64'(ec));
    check("zf", 64'(zf), 64'(ez));
    check("sf", 64'(sf), 64'(es));
    check("of", 64'(of), 64'(eo));
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    if (mode == 2) begin
      @(posedge clk); #1;
      check("b2b_accept", 64'(busy), 64'(1));
      start = 1'b0;
      edges = 0; seen = 0;
      while (!seen && edges < 200) begin
        @(posedge clk); #1;
        edges++;
        if (done) seen = 1;
      end
      check("b2b_done_edge", 64'(edges), 64'(W));
      check("b2b_result", result, er);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      check("no_restart", 64'(busy), 64'(0));
      check("result_hold", result, er);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int dcnt;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op_i = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", result, 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_flags", 64'({zf, sf, of}), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    run_op(64'd5, 64'd3, 1'b0, 0);
    run_op(64'd5, 64'd5, 1'b1, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    run_op(64'd0, 64'd1, 1'b1, 1);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 2);

    for (int i = 0; i < 14; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 3) ra = {1'b0, {(W-1){1'b1}}};
      run_op(ra, rb, 1'($urandom_range(1, 0)), i % 3);
    end

    // Asynchronous reset during bit 30 of an add.
    @(negedge clk);
    a_i = 64'hFFFF_0000_FFFF_FFFF; b_i = 64'h0000_0000_8000_0001; op_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_result", result, 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
    check("abort_flags", 64'({zf, sf, of}), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'(0));
    run_op(64'd2, 64'd2, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
